r5p_soc_uart_rx: RTL

// - UART receiver peripheral for the r5p SoC; it deserializes the board RX pin (FPGA_RX on Tang Nano 9k).
// - It is the receiving end of the SoC UART TX line, so a TX->RX loopback returns every transmitted byte.
// - Frames are 8N1, LSB first, sampled at mid-bit from a clock divider.
// - Received bytes are buffered in a small FIFO and delivered on a valid/ready stream.
// - A bus adapter or the CPU polls that stream.
//

---
 rtl/r5p_uart_pkg.sv | 14 +
 rtl/r5p_uart_fifo.sv | 38 +++
 rtl/r5p_soc_uart_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/r5p_uart_pkg.sv
// r5p_uart_pkg: shared UART state encoding and baud divider helper.
package r5p_uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/r5p_uart_fifo.sv
// r5p_uart_fifo: synchronous DW x DEP FIFO; a push while full only lands if a pop frees a slot.
module r5p_uart_fifo #(
  parameter int DW  = 8,
  parameter int DEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DW-1:0]         push_dat,
  input  logic                  pop,
  output logic [DW-1:0]         pop_dat,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEP):0]  cnt
);
  localparam int AW = $clog2(DEP);
  logic [DW-1:0] mem_q [DEP];
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic          do_push, do_pop;
  assign empty   = wp_q == rp_q;
  assign full    = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign cnt     = wp_q - rp_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wp_d    = wp_q + {{AW{1'b0}}, do_push};
  assign rp_d    = rp_q + {{AW{1'b0}}, do_pop};
  assign pop_dat = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= push_dat;
endmodule

// File: rtl/r5p_soc_uart_rx.sv
// r5p_soc_uart_rx: 8N1 UART receiver with RX FIFO and sticky status flags.
// Define R5P_UART_RX_PARITY_EN for 8E1 frames with parity checking.
module r5p_soc_uart_rx
  import r5p_uart_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 115_200,
  parameter int DW       = 8,
  parameter int FIFO_DEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_rxd,
  output logic                       rx_vld,
  input  logic                       rx_rdy,
  output logic [DW-1:0]              rx_dat,
  output logic [$clog2(FIFO_DEP):0]  rx_cnt,
  output logic                       sts_ferr,
  output logic                       sts_ovf,
  output logic                       sts_perr,
  input  logic                       sts_clr
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(DW);
`ifdef R5P_UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = ST_STOP;
`endif
  uart_rx_state_t state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q, rxs, fall, tick, push, pop, full, empty, drop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          ferr_q, ferr_d, ferr_set, ovf_q, ovf_d;
`ifdef R5P_UART_RX_PARITY_EN
  logic          perr_q, perr_d, perr_set, bad_q, bad_d;
`endif
  assign rxs  = sync_q[1];
  assign fall = !rxs && prev_q;
  assign tick = cnt_q == '0;
  assign pop  = rx_vld && rx_rdy;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - CW'(1);
    idx_d    = idx_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef R5P_UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: if (fall) begin
        state_d = ST_START;
        cnt_d   = CW'(DIV / 2 - 1);
      end
      ST_START: if (tick) begin
        state_d = rxs ? ST_IDLE : ST_DATA;
        cnt_d   = CW'(DIV - 1);
        idx_d   = '0;
      end
      ST_DATA: if (tick) begin
        sh_d    = {rxs, sh_q[DW-1:1]};
        cnt_d   = CW'(DIV - 1);
        idx_d   = idx_q + IW'(1);
        state_d = idx_q == IW'(DW - 1) ? AFTER_DATA : ST_DATA;
      end
`ifdef R5P_UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        perr_set = rxs != ^sh_q;
        cnt_d    = CW'(DIV - 1);
        state_d  = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
        push     = rxs && !drop;
        ferr_set = !rxs;
        state_d  = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ferr_d = sts_clr ? 1'b0 : ferr_q | ferr_set;
    ovf_d  = sts_clr ? 1'b0 : ovf_q | (push && full && !pop);
`ifdef R5P_UART_RX_PARITY_EN
    perr_d = sts_clr ? 1'b0 : perr_q | perr_set;
    bad_d  = state_q == ST_START ? 1'b0 : bad_q | perr_set;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rxd};
      prev_q  <= rxs;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
`ifdef R5P_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perr_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      perr_q <= perr_d;
      bad_q  <= bad_d;
    end
  assign drop     = bad_q;
  assign sts_perr = perr_q;
`else
  assign drop     = 1'b0;
  assign sts_perr = 1'b0;
`endif
  assign sts_ferr = ferr_q;
  assign sts_ovf  = ovf_q;
  assign rx_vld   = !empty;
  r5p_uart_fifo #(.DW(DW), .DEP(FIFO_DEP)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (sh_q),
    .pop      (pop),
    .pop_dat  (rx_dat),
    .full     (full),
    .empty    (empty),
    .cnt      (rx_cnt)
  );
endmodule
